// File: rtl/ins_encoder_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ins_encoder_loader_if
// Purpose  : Instruction-field handshake and byte-wide memory write bus.
// Revision : 1.0
// ============================================================================
interface ins_encoder_loader_if #(
    parameter int ADDR_W = 8
);
    logic              InValid;
    logic              InReady;
    logic [5:0]        InOp;
    logic [4:0]        InRs;
    logic [4:0]        InRt;
    logic [4:0]        InRd;
    logic [4:0]        InSa;
    logic [15:0]       InImm;
    logic [25:0]       InTarget;
    logic [ADDR_W-1:0] MemAddr;
    logic [7:0]        MemData;
    logic              MemWE;

    // Instruction source and memory sink side
    modport master (
        output InValid, InOp, InRs, InRt, InRd, InSa, InImm, InTarget,
        input  InReady, MemAddr, MemData, MemWE
    );

    // Encoder/loader side
    modport slave (
        input  InValid, InOp, InRs, InRt, InRd, InSa, InImm, InTarget,
        output InReady, MemAddr, MemData, MemWE
    );
endinterface
`default_nettype wire

// File: rtl/ins_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : ins_encoder_loader
// Purpose  : Packs instruction fields into 32-bit words and loads them
//            big-endian, one byte per cycle, into instruction memory.
// Revision : 1.0
// ============================================================================
module ins_encoder_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  wire logic              CLK,
    input  wire logic              Reset,
    ins_encoder_loader_if.slave    bus,
    output logic [31:0]            LastWord,
    output logic [ADDR_W-2:0]      WordCount,
    output logic                   IllegalOp,
    output logic                   Wrapped,
    output logic                   Halted
);
    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_B0   = 3'd1;
    localparam logic [2:0] c_S_B1   = 3'd2;
    localparam logic [2:0] c_S_B2   = 3'd3;
    localparam logic [2:0] c_S_B3   = 3'd4;
    localparam logic [2:0] c_S_HALT = 3'd5;

    localparam logic [5:0] c_OP_ADD  = 6'b000000;
    localparam logic [5:0] c_OP_SUB  = 6'b000010;
    localparam logic [5:0] c_OP_AND  = 6'b010001;
    localparam logic [5:0] c_OP_OR   = 6'b010010;
    localparam logic [5:0] c_OP_SLT  = 6'b011100;
    localparam logic [5:0] c_OP_SLL  = 6'b011000;
    localparam logic [5:0] c_OP_ADDI = 6'b000001;
    localparam logic [5:0] c_OP_ORI  = 6'b010000;
    localparam logic [5:0] c_OP_SW   = 6'b100110;
    localparam logic [5:0] c_OP_LW   = 6'b100111;
    localparam logic [5:0] c_OP_BEQ  = 6'b110000;
    localparam logic [5:0] c_OP_BNE  = 6'b110001;
    localparam logic [5:0] c_OP_BGTZ = 6'b110010;
    localparam logic [5:0] c_OP_J    = 6'b111000;
    localparam logic [5:0] c_OP_HALT = 6'b111111;

    localparam logic [ADDR_W-1:0] c_WORD_BYTES = ADDR_W'(4);

    logic [2:0]        r_state;
    logic [2:0]        w_nextState;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptrNext;
    logic [31:0]       r_lastWord;
    logic [ADDR_W-2:0] r_wordCount;
    logic              r_illegalOp;
    logic              r_wrapped;
    logic [31:0]       w_encWord;
    logic              w_legal;
    logic              w_xfer;
    logic              w_isHalt;
    logic              w_inReady;
    logic              w_memWE;
    logic [ADDR_W-1:0] w_memAddr;
    logic [7:0]        w_memData;

    // Fields a format does not use are forced to zero
    always_comb begin
        w_encWord = '0;
        w_legal   = 1'b1;
        case (bus.InOp)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_SLT:
                w_encWord = {bus.InOp, bus.InRs, bus.InRt, bus.InRd, 11'b0};
            c_OP_SLL:
                w_encWord = {bus.InOp, 5'b0, bus.InRt, bus.InRd, bus.InSa, 6'b0};
            c_OP_ADDI, c_OP_ORI, c_OP_SW, c_OP_LW, c_OP_BEQ, c_OP_BNE:
                w_encWord = {bus.InOp, bus.InRs, bus.InRt, bus.InImm};
            c_OP_BGTZ:
                w_encWord = {bus.InOp, bus.InRs, 5'b0, bus.InImm};
            c_OP_J:
                w_encWord = {bus.InOp, bus.InTarget};
            c_OP_HALT:
                w_encWord = {bus.InOp, 26'b0};
            default:
                w_legal = 1'b0;
        endcase
    end

    assign w_xfer    = bus.InValid && (r_state == c_S_IDLE);
    assign w_isHalt  = (r_lastWord[31:26] == c_OP_HALT);
    assign w_ptrNext = r_ptr + c_WORD_BYTES;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_S_IDLE: if (w_xfer && w_legal) w_nextState = c_S_B0;
            c_S_B0:   w_nextState = c_S_B1;
            c_S_B1:   w_nextState = c_S_B2;
            c_S_B2:   w_nextState = c_S_B3;
            c_S_B3:   w_nextState = w_isHalt ? c_S_HALT : c_S_IDLE;
            c_S_HALT: w_nextState = c_S_HALT;
            default:  w_nextState = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_inReady = 1'b0;
        w_memWE   = 1'b0;
        w_memAddr = r_ptr;
        w_memData = 8'h00;
        case (r_state)
            c_S_IDLE: w_inReady = 1'b1;
            c_S_B0: begin
                w_memWE   = 1'b1;
                w_memData = r_lastWord[31:24];
            end
            c_S_B1: begin
                w_memWE   = 1'b1;
                w_memAddr = r_ptr + ADDR_W'(1);
                w_memData = r_lastWord[23:16];
            end
            c_S_B2: begin
                w_memWE   = 1'b1;
                w_memAddr = r_ptr + ADDR_W'(2);
                w_memData = r_lastWord[15:8];
            end
            c_S_B3: begin
                w_memWE   = 1'b1;
                w_memAddr = r_ptr + ADDR_W'(3);
                w_memData = r_lastWord[7:0];
            end
            default: ;
        endcase
    end

    // The encoded word doubles as LastWord; it only changes on legal transfers
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_ptr       <= BASE_ADDR;
            r_lastWord  <= '0;
            r_wordCount <= '0;
            r_illegalOp <= 1'b0;
            r_wrapped   <= 1'b0;
        end else begin
            if (w_xfer) begin
                if (w_legal) begin
                    r_lastWord <= w_encWord;
                end else begin
                    r_illegalOp <= 1'b1;
                end
            end
            if (r_state == c_S_B3) begin
                r_ptr <= w_ptrNext;
                if (w_ptrNext == '0) begin
                    r_wrapped <= 1'b1;
                end
                if (r_wordCount != '1) begin
                    r_wordCount <= r_wordCount + 1'b1;
                end
            end
        end
    end

    assign bus.InReady = w_inReady;
    assign bus.MemWE   = w_memWE;
    assign bus.MemAddr = w_memAddr;
    assign bus.MemData = w_memData;
    assign LastWord    = r_lastWord;
    assign WordCount   = r_wordCount;
    assign IllegalOp   = r_illegalOp;
    assign Wrapped     = r_wrapped;
    assign Halted      = (r_state == c_S_HALT);
endmodule
`default_nettype wire

// File: tb/tb_ins_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ins_encoder_loader
// Purpose  : Scoreboard bench for ins_encoder_loader (ADDR_W=8 and ADDR_W=4).
// Revision : 1.0
// ============================================================================
module tb_ins_encoder_loader;
    logic clk;
    logic rst;

    ins_encoder_loader_if #(.ADDR_W(8)) ifA ();
    ins_encoder_loader_if #(.ADDR_W(4)) ifB ();

    logic [31:0] lastWordA, lastWordB;
    logic [6:0]  wordCountA;
    logic [2:0]  wordCountB;
    logic        illegalA, wrappedA, haltedA;
    logic        illegalB, wrappedB, haltedB;

    ins_encoder_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) dutA (
        .CLK(clk), .Reset(rst), .bus(ifA),
        .LastWord(lastWordA), .WordCount(wordCountA),
        .IllegalOp(illegalA), .Wrapped(wrappedA), .Halted(haltedA)
    );

    ins_encoder_loader #(.ADDR_W(4), .BASE_ADDR(4'd0)) dutB (
        .CLK(clk), .Reset(rst), .bus(ifB),
        .LastWord(lastWordB), .WordCount(wordCountB),
        .IllegalOp(illegalB), .Wrapped(wrappedB), .Halted(haltedB)
    );

    int nChecks = 0;
    int nFails  = 0;
    logic [31:0] qA[$];
    logic [31:0] qB[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected byte writes packed as {addr, data}
    task automatic expectWord(input int sel, input logic [7:0] addr, input logic [31:0] word);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            e = {16'h0, addr + 8'(k), word[31-8*k -: 8]};
            if (sel == 0) qA.push_back(e);
            else          qB.push_back({e[31:12], 4'h0, e[11:0]} & 32'h0000_0FFF);
        end
    endtask

    always @(negedge clk) begin
        if (ifA.MemWE) begin
            if (qA.size() == 0) begin
                nChecks++; nFails++;
                $display("FAIL memA_unexpected: got addr %h data %h, expected no write", ifA.MemAddr, ifA.MemData);
            end else begin
                check("memA_write", {16'h0, ifA.MemAddr, ifA.MemData}, qA.pop_front());
            end
        end
        if (ifB.MemWE) begin
            if (qB.size() == 0) begin
                nChecks++; nFails++;
                $display("FAIL memB_unexpected: got addr %h data %h, expected no write", ifB.MemAddr, ifB.MemData);
            end else begin
                check("memB_write", {20'h0, ifB.MemAddr, ifB.MemData}, qB.pop_front());
            end
        end
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? ifA.InReady : ifB.InReady;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
                         input logic [15:0] imm, input logic [25:0] tgt);
        if (sel == 0) begin
            ifA.InValid = v; ifA.InOp = op; ifA.InRs = rs; ifA.InRt = rt;
            ifA.InRd = rd; ifA.InSa = sa; ifA.InImm = imm; ifA.InTarget = tgt;
        end else begin
            ifB.InValid = v; ifB.InOp = op; ifB.InRs = rs; ifB.InRt = rt;
            ifB.InRd = rd; ifB.InSa = sa; ifB.InImm = imm; ifB.InTarget = tgt;
        end
    endtask

    task automatic waitReady(input int sel, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rdy(sel) && cyc < 50);
        if (!rdy(sel)) check("ready_timeout", 32'(rdy(sel)), 32'd1);
    endtask

    // One-cycle transfer; fields are scrambled right after the edge
    task automatic send(input int sel, input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sa, input logic [15:0] imm,
                        input logic [25:0] tgt);
        int cyc;
        if (!rdy(sel)) waitReady(sel, cyc);
        drive(sel, 1'b1, op, rs, rt, rd, sa, imm, tgt);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              16'($urandom), 26'($urandom));
    endtask

    task automatic checkResetA();
        check("rstA_InReady",   32'(ifA.InReady), 32'd1);
        check("rstA_MemWE",     32'(ifA.MemWE),   32'd0);
        check("rstA_MemAddr",   32'(ifA.MemAddr), 32'd0);
        check("rstA_MemData",   32'(ifA.MemData), 32'd0);
        check("rstA_LastWord",  lastWordA,        32'd0);
        check("rstA_WordCount", 32'(wordCountA),  32'd0);
        check("rstA_IllegalOp", 32'(illegalA),    32'd0);
        check("rstA_Wrapped",   32'(wrappedA),    32'd0);
        check("rstA_Halted",    32'(haltedA),     32'd0);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        drive(0, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0, '0, '0, '0, '0);
        #22 rst = 1'b0;
        @(negedge clk);
        checkResetA();

        // add with garbage sa/imm
        expectWord(0, 8'd0, 32'h0022_1800);
        send(0, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd5, 16'hABCD, 26'h3FF_FFFF);
        waitReady(0, cyc);
        check("add_latency", 32'(cyc), 32'd5);
        check("add_LastWord", lastWordA, 32'h0022_1800);
        check("add_WordCount", 32'(wordCountA), 32'd1);
        check("idle_MemAddr", 32'(ifA.MemAddr), 32'd4);
        check("idle_MemData", 32'(ifA.MemData), 32'd0);

        expectWord(0, 8'd4, 32'h0422_FFFF);
        send(0, 6'b000001, 5'd1, 5'd2, 5'd31, 5'd31, 16'hFFFF, 26'h0);
        waitReady(0, cyc);
        check("addi_LastWord", lastWordA, 32'h0422_FFFF);

        expectWord(0, 8'd8, 32'h6002_1900);
        send(0, 6'b011000, 5'd7, 5'd2, 5'd3, 5'd4, 16'h1234, 26'h0);
        waitReady(0, cyc);
        check("sll_LastWord", lastWordA, 32'h6002_1900);

        // Illegal opcode: consumed, nothing written
        send(0, 6'b000011, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5555, 26'h0);
        waitReady(0, cyc);
        check("ill_ready_latency", 32'(cyc), 32'd1);
        check("ill_IllegalOp", 32'(illegalA), 32'd1);
        check("ill_MemAddr", 32'(ifA.MemAddr), 32'd12);
        check("ill_LastWord", lastWordA, 32'h6002_1900);

        expectWord(0, 8'd12, 32'h0022_1800);
        send(0, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        waitReady(0, cyc);
        check("add2_WordCount", 32'(wordCountA), 32'd4);

        expectWord(0, 8'd16, 32'hC8A0_8001);
        send(0, 6'b110010, 5'd5, 5'd9, 5'd7, 5'd3, 16'h8001, 26'h0);
        waitReady(0, cyc);
        check("bgtz_LastWord", lastWordA, 32'hC8A0_8001);

        expectWord(0, 8'd20, 32'h4BFF_F800);
        send(0, 6'b010010, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h0);
        waitReady(0, cyc);
        check("or_LastWord", lastWordA, 32'h4BFF_F800);

        // sw interrupted by reset during B2: only bytes 0 and 1 land
        qA.push_back({16'h0, 8'd24, 8'h98});
        qA.push_back({16'h0, 8'd25, 8'h43});
        send(0, 6'b100110, 5'd2, 5'd3, 5'd0, 5'd0, 16'h0010, 26'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_MemWE", 32'(ifA.MemWE), 32'd0);
        checkResetA();
        #5 rst = 1'b0;

        expectWord(0, 8'd0, 32'hE000_0004);
        send(0, 6'b111000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd4);
        waitReady(0, cyc);
        check("j_LastWord", lastWordA, 32'hE000_0004);

        expectWord(0, 8'd4, 32'hFC00_0000);
        send(0, 6'b111111, 5'd3, 5'd3, 5'd3, 5'd3, 16'hFFFF, 26'h0);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!haltedA && cyc < 50);
        check("halt_latency", 32'(cyc), 32'd5);
        check("halt_Halted", 32'(haltedA), 32'd1);
        check("halt_InReady", 32'(ifA.InReady), 32'd0);
        check("halt_WordCount", 32'(wordCountA), 32'd2);
        drive(0, 1'b1, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        repeat (6) @(negedge clk);
        drive(0, 1'b0, 6'b000000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
        check("halt_stays", 32'(haltedA), 32'd1);
        check("halt_noWE", 32'(ifA.MemWE), 32'd0);

        // Small memory: fourth word wraps the pointer
        expectWord(1, 8'd0, 32'h0022_1800);
        send(1, 6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        expectWord(1, 8'd4, 32'h0422_FFFF);
        send(1, 6'b000001, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        expectWord(1, 8'd8, 32'h6002_1900);
        send(1, 6'b011000, 5'd0, 5'd2, 5'd3, 5'd4, 16'h0, 26'h0);
        waitReady(1, cyc);
        check("B_noWrapYet", 32'(wrappedB), 32'd0);
        expectWord(1, 8'd12, 32'hE000_0004);
        send(1, 6'b111000, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'd4);
        waitReady(1, cyc);
        check("B_Wrapped", 32'(wrappedB), 32'd1);
        check("B_addrAfterWrap", 32'(ifB.MemAddr), 32'd0);
        expectWord(1, 8'd0, 32'hC064_1234);
        send(1, 6'b110000, 5'd3, 5'd4, 5'd0, 5'd0, 16'h1234, 26'h0);
        waitReady(1, cyc);
        check("B_WordCount", 32'(wordCountB), 32'd5);
        check("B_LastWord", lastWordB, 32'hC064_1234);

        repeat (3) @(negedge clk);
        check("qA_drained", 32'(qA.size()), 32'd0);
        check("qB_drained", 32'(qB.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
`default_nettype wire
